move_check_ctrl: RTL and testbench
==================================

# move_check_ctrl

Sequencer in front of the board validator's per-piece move checkers (queen, rook, bishop, knight, king, pawn). It accepts one move request at a time and pre-screens trivial illegal cases. It then dispatches the geometry check to the external checker selected by piece type and, for sliding and double-step moves, scans the intermediate squares one per cycle for blockers. It returns a single legal/illegal verdict to game-play control over a valid/ready handshake.

## Interface
- TIMEOUT_CYCLES, 16: max cycles to wait for checker done (used only with macro, see Configuration).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  move request present.
- req_ready  out  1  controller idle, can accept request.
- old_x, old_y, new_x, new_y  in  3 each  source/destination square.
- board_in  in  4 x [8][8]  board state; must be held stable from accept until response handshake.
- chk_start  out  1  one-cycle pulse starting the selected checker.
- chk_piece  out  4  registered piece code for checker mux select.
- chk_h_delta, chk_v_delta  out  3 each  registered |dx|, |dy|.
- chk_done  in  1  checker result valid (checker's valid_output).
- chk_legal  in  1  checker geometry verdict (checker's valid_move), sampled with chk_done.
- resp_valid  out  1  verdict available.
- resp_legal  out  1  1 = move legal.
- resp_err  out  1  1 = verdict forced by timeout (macro builds only, else tied 0).
- resp_ready  in  1  consumer accepts verdict.

## Operation
- Piece code: 0 = empty; bits[2:0] type 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king; bit3 colour (0 white, 1 black).
- States: IDLE, PRECHECK, DISPATCH, WAIT_CHK, SCAN, DONE.
- IDLE: req_ready=1. On req_valid, latch coordinates, piece = board_in[old_x][old_y], and deltas (3-bit absolute differences), then go to PRECHECK.
- PRECHECK: the move is illegal, going straight to DONE with legal=0, if it is a null move (old==new), if the source is empty, or if the destination is non-empty with the same colour bit. Otherwise go to DISPATCH.
- DISPATCH: chk_start=1 for exactly one cycle, then go to WAIT_CHK.
- WAIT_CHK: hold until chk_done. If !chk_legal, go to DONE illegal. Otherwise go to SCAN for bishop, rook or queen, and for a pawn with h_delta=0 and v_delta=2. All other pieces go to DONE legal.
- SCAN: cursor starts at old + step, where step per axis is sign(new-old) in {-1,0,+1}. Each cycle:
  - cursor==new: DONE legal.
  - board_in[cursor]!=0: DONE illegal.
  - otherwise cursor += step.
- DONE: resp_valid=1 with resp_legal/resp_err held stable until resp_ready, then go to IDLE.
- chk_start never asserts outside DISPATCH. A chk_done arriving outside WAIT_CHK is ignored.

## Timing
- Reset values (state IDLE): req_ready=1; chk_start, resp_valid, resp_legal and resp_err are 0; chk_piece and deltas are 0.
- Reset asserted mid-transaction aborts it immediately with no response. A request held across reset release is accepted on the first clock after release.
- Accept at edge T puts PRECHECK at T+1. A PRECHECK reject gives resp_valid at T+2.
- Dispatched path: chk_start at T+2. With checker done N cycles after start, non-sliding resp_valid appears at T+3+N.
- SCAN adds k+1 cycles for k intermediate squares (max 6 intermediate, 7 SCAN cycles).
- resp_valid & resp_ready at edge R: IDLE at R+1, so req_ready=1 and a new accept is possible at R+1. No back-to-back acceptance without an IDLE cycle.

## Configuration
- MOVE_CHK_TIMEOUT_EN defined: WAIT_CHK has a counter of width $clog2(TIMEOUT_CYCLES+1). The counter is cleared in DISPATCH. When it reaches TIMEOUT_CYCLES without chk_done, go to DONE with legal=0, err=1.
- Undefined: no counter, WAIT_CHK waits indefinitely, resp_err tied 0.

## Structure
- Shared package chess_move_pkg: piece_t enum (empty..king), colour-bit constant, ctrl_state_t enum, default TIMEOUT_CYCLES.
- Sub-module move_path_scanner holds the cursor register, step computation, arrival/blocked flags, and a load/advance interface driven by the FSM.
- The FSM, PRECHECK logic and handshake live in move_check_ctrl.

## Test plan
- White queen d1 to d5 (3,0 to 3,4), path clear, checker legal after 2 cycles -> chk_h_delta=0, chk_v_delta=4, 4 SCAN cycles, resp_legal=1.
- Same queen move with white pawn at d3 -> resp_legal=0 after exactly 2 SCAN cycles.
- Knight b1 to c3 with chk_legal=1 -> no SCAN, resp_valid 3+N cycles after accept, legal=1.
- Null move, empty source, or capture of own colour -> chk_start never pulses, resp_valid at T+2, legal=0.
- MOVE_CHK_TIMEOUT_EN, TIMEOUT_CYCLES=16, chk_done never asserted -> resp_valid with legal=0, err=1. Reset pulsed mid-SCAN -> resp_valid=0, req_ready=1 immediately.
- resp_ready held low 5 cycles -> verdict stable throughout, req_ready=1 the cycle after handshake.

Source files
------------

// File: rtl/chess_move_pkg.sv
// Shared types and helpers for the move-check sequencer and its path scanner.
package chess_move_pkg;

    typedef enum logic [2:0] {
        PIECE_EMPTY  = 3'd0,
        PIECE_PAWN   = 3'd1,
        PIECE_KNIGHT = 3'd2,
        PIECE_BISHOP = 3'd3,
        PIECE_ROOK   = 3'd4,
        PIECE_QUEEN  = 3'd5,
        PIECE_KING   = 3'd6
    } piece_t;

    localparam int unsigned COLOUR_BIT             = 3;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [2:0] {
        IDLE,
        PRECHECK,
        DISPATCH,
        WAIT_CHK,
        SCAN,
        DONE
    } ctrl_state_t;

    function automatic logic [2:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Per-axis unit step as a 3-bit two's complement value (-1 wraps to 3'b111).
    function automatic logic [2:0] step_of(input logic [2:0] from, input logic [2:0] to);
        if (to > from) begin
            return 3'd1;
        end else if (to < from) begin
            return 3'b111;
        end
        return 3'd0;
    endfunction

endpackage

// File: rtl/move_path_scanner.sv
// Walks a cursor from the square after the source towards the destination,
// flagging arrival and blockers on the square currently under the cursor.
module move_path_scanner
    import chess_move_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   advance,
    input  logic [2:0]             old_x,
    input  logic [2:0]             old_y,
    input  logic [2:0]             new_x,
    input  logic [2:0]             new_y,
    input  logic [7:0][7:0][3:0]   board_in,
    output logic                   arrived,
    output logic                   blocked
);

    logic [2:0] step_x;
    logic [2:0] step_y;
    logic [2:0] cur_x;
    logic [2:0] cur_y;

    assign step_x = step_of(old_x, new_x);
    assign step_y = step_of(old_y, new_y);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_x <= 3'd0;
            cur_y <= 3'd0;
        end else if (load) begin
            cur_x <= old_x + step_x;
            cur_y <= old_y + step_y;
        end else if (advance) begin
            cur_x <= cur_x + step_x;
            cur_y <= cur_y + step_y;
        end
    end

    assign arrived = (cur_x == new_x) && (cur_y == new_y);
    assign blocked = (board_in[cur_x][cur_y] != 4'd0);

endmodule

// File: rtl/move_check_ctrl.sv
// Move-check sequencer: pre-screen, checker dispatch, path scan, verdict handshake.
// Define MOVE_CHK_TIMEOUT_EN to bound the checker wait by TIMEOUT_CYCLES (reports resp_err).
module move_check_ctrl
    import chess_move_pkg::*;
`ifdef MOVE_CHK_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)
`endif
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             old_x,
    input  logic [2:0]             old_y,
    input  logic [2:0]             new_x,
    input  logic [2:0]             new_y,
    input  logic [7:0][7:0][3:0]   board_in,
    output logic                   chk_start,
    output logic [3:0]             chk_piece,
    output logic [2:0]             chk_h_delta,
    output logic [2:0]             chk_v_delta,
    input  logic                   chk_done,
    input  logic                   chk_legal,
    output logic                   resp_valid,
    output logic                   resp_legal,
    output logic                   resp_err,
    input  logic                   resp_ready
);

    ctrl_state_t state;
    ctrl_state_t next_state;

    logic [2:0] old_x_q;
    logic [2:0] old_y_q;
    logic [2:0] new_x_q;
    logic [2:0] new_y_q;
    logic [3:0] piece_q;
    logic [2:0] h_delta_q;
    logic [2:0] v_delta_q;
    logic       legal_q;

    logic       accept;
    logic       finish;
    logic       finish_legal;
    logic       finish_err;
    logic       scan_load;
    logic       scan_advance;
    logic       scan_arrived;
    logic       scan_blocked;

    logic [3:0] dest_piece;
    piece_t     piece_type;
    logic       reject;
    logic       needs_scan;

    assign dest_piece = board_in[new_x_q][new_y_q];
    assign piece_type = piece_t'(piece_q[2:0]);

    assign reject = ((old_x_q == new_x_q) && (old_y_q == new_y_q))
                 || (piece_q == 4'd0)
                 || ((dest_piece != 4'd0) && (dest_piece[COLOUR_BIT] == piece_q[COLOUR_BIT]));

    // Sliders and the pawn double step are the only moves with intermediate squares.
    assign needs_scan = (piece_type == PIECE_BISHOP)
                     || (piece_type == PIECE_ROOK)
                     || (piece_type == PIECE_QUEEN)
                     || ((piece_type == PIECE_PAWN) && (h_delta_q == 3'd0) && (v_delta_q == 3'd2));

`ifdef MOVE_CHK_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer;
    logic          err_q;
    logic          timed_out;

    assign timed_out = (timer == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (state == DISPATCH) begin
            timer <= '0;
        end else if ((state == WAIT_CHK) && !chk_done && !timed_out) begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (finish) begin
            err_q <= finish_err;
        end
    end

    assign resp_err = resp_valid && err_q;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        req_ready    = 1'b0;
        chk_start    = 1'b0;
        resp_valid   = 1'b0;
        accept       = 1'b0;
        finish       = 1'b0;
        finish_legal = 1'b0;
        finish_err   = 1'b0;
        scan_load    = 1'b0;
        scan_advance = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = PRECHECK;
                end
            end
            PRECHECK: begin
                if (reject) begin
                    finish = 1'b1;
                end else begin
                    next_state = DISPATCH;
                end
            end
            DISPATCH: begin
                chk_start  = 1'b1;
                next_state = WAIT_CHK;
            end
            WAIT_CHK: begin
                if (chk_done) begin
                    if (!chk_legal) begin
                        finish = 1'b1;
                    end else if (needs_scan) begin
                        scan_load  = 1'b1;
                        next_state = SCAN;
                    end else begin
                        finish       = 1'b1;
                        finish_legal = 1'b1;
                    end
                end
`ifdef MOVE_CHK_TIMEOUT_EN
                else if (timed_out) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
`endif
            end
            SCAN: begin
                if (scan_arrived) begin
                    finish       = 1'b1;
                    finish_legal = 1'b1;
                end else if (scan_blocked) begin
                    finish = 1'b1;
                end else begin
                    scan_advance = 1'b1;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (finish) begin
            next_state = DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            old_x_q   <= 3'd0;
            old_y_q   <= 3'd0;
            new_x_q   <= 3'd0;
            new_y_q   <= 3'd0;
            piece_q   <= 4'd0;
            h_delta_q <= 3'd0;
            v_delta_q <= 3'd0;
        end else if (accept) begin
            old_x_q   <= old_x;
            old_y_q   <= old_y;
            new_x_q   <= new_x;
            new_y_q   <= new_y;
            piece_q   <= board_in[old_x][old_y];
            h_delta_q <= abs_diff(old_x, new_x);
            v_delta_q <= abs_diff(old_y, new_y);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            legal_q <= 1'b0;
        end else if (finish) begin
            legal_q <= finish_legal;
        end
    end

    assign resp_legal  = resp_valid && legal_q;
    assign chk_piece   = piece_q;
    assign chk_h_delta = h_delta_q;
    assign chk_v_delta = v_delta_q;

    move_path_scanner u_scanner (
        .clk      (clk),
        .reset    (reset),
        .load     (scan_load),
        .advance  (scan_advance),
        .old_x    (old_x_q),
        .old_y    (old_y_q),
        .new_x    (new_x_q),
        .new_y    (new_y_q),
        .board_in (board_in),
        .arrived  (scan_arrived),
        .blocked  (scan_blocked)
    );

endmodule

// File: tb/tb_move_check_ctrl.sv
// Directed bench for move_check_ctrl with a latency-programmable checker model.
module tb_move_check_ctrl;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [2:0]           old_x = 3'd0;
    logic [2:0]           old_y = 3'd0;
    logic [2:0]           new_x = 3'd0;
    logic [2:0]           new_y = 3'd0;
    logic [7:0][7:0][3:0] board = '0;
    logic                 chk_start;
    logic [3:0]           chk_piece;
    logic [2:0]           chk_h_delta;
    logic [2:0]           chk_v_delta;
    logic                 chk_done = 1'b0;
    logic                 chk_legal = 1'b0;
    logic                 resp_valid;
    logic                 resp_legal;
    logic                 resp_err;
    logic                 resp_ready = 1'b0;

    int   checks = 0;
    int   failures = 0;
    int   chk_latency = 1;
    logic chk_verdict = 1'b1;
    logic chk_enable = 1'b1;
    int   start_count = 0;

    always #5 clk = ~clk;

    move_check_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .old_x       (old_x),
        .old_y       (old_y),
        .new_x       (new_x),
        .new_y       (new_y),
        .board_in    (board),
        .chk_start   (chk_start),
        .chk_piece   (chk_piece),
        .chk_h_delta (chk_h_delta),
        .chk_v_delta (chk_v_delta),
        .chk_done    (chk_done),
        .chk_legal   (chk_legal),
        .resp_valid  (resp_valid),
        .resp_legal  (resp_legal),
        .resp_err    (resp_err),
        .resp_ready  (resp_ready)
    );

    // Checker model: answers chk_latency cycles after the start pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_start === 1'b1) begin
                start_count++;
                if (chk_enable) begin
                    repeat (chk_latency) @(posedge clk);
                    #1;
                    chk_done  = 1'b1;
                    chk_legal = chk_verdict;
                    @(posedge clk);
                    #1;
                    chk_done  = 1'b0;
                    chk_legal = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] ox, input logic [2:0] oy,
                                 input logic [2:0] nx, input logic [2:0] ny);
        old_x     = ox;
        old_y     = oy;
        new_x     = nx;
        new_y     = ny;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic waitResp(output int cycles);
        cycles = 0;
        while (resp_valid !== 1'b1 && cycles < 60) begin
            tick();
            cycles++;
        end
    endtask

    task automatic finishResp(input string tag);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checkOutput({tag, "_ready_after_hs"}, req_ready, 1);
        checkOutput({tag, "_valid_after_hs"}, resp_valid, 0);
    endtask

    // Full transaction: expected cycles counted from the accept edge to resp_valid.
    task automatic runMove(input string tag,
                           input logic [2:0] ox, input logic [2:0] oy,
                           input logic [2:0] nx, input logic [2:0] ny,
                           input logic [2:0] exp_h, input logic [2:0] exp_v,
                           input int latency, input logic verdict,
                           input int exp_cycles, input logic exp_legal, input int exp_starts);
        int cycles;
        start_count = 0;
        chk_latency = latency;
        chk_verdict = verdict;
        applyStimulus(ox, oy, nx, ny);
        checkOutput({tag, "_h_delta"}, chk_h_delta, exp_h);
        checkOutput({tag, "_v_delta"}, chk_v_delta, exp_v);
        waitResp(cycles);
        checkOutput({tag, "_latency"}, cycles, exp_cycles);
        checkOutput({tag, "_legal"}, resp_legal, exp_legal);
        checkOutput({tag, "_err"}, resp_err, 0);
        checkOutput({tag, "_starts"}, start_count, exp_starts);
        finishResp(tag);
    endtask

    initial begin
        int cycles;

        tick();
        tick();
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_chk_start", chk_start, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_legal", resp_legal, 0);
        checkOutput("rst_resp_err", resp_err, 0);
        checkOutput("rst_chk_piece", chk_piece, 0);
        checkOutput("rst_h_delta", chk_h_delta, 0);
        checkOutput("rst_v_delta", chk_v_delta, 0);
        reset = 1'b0;
        tick();

        board[3][0] = 4'd5;
        start_count = 0;
        chk_latency = 2;
        chk_verdict = 1'b1;
        applyStimulus(3'd3, 3'd0, 3'd3, 3'd4);
        checkOutput("queen_piece", chk_piece, 5);
        checkOutput("queen_req_busy", req_ready, 0);
        waitResp(cycles);
        checkOutput("queen_clear_latency", cycles, 8);
        checkOutput("queen_clear_legal", resp_legal, 1);
        finishResp("queen_clear");

        board[3][2] = 4'd1;
        runMove("queen_blocked", 3, 0, 3, 4, 0, 4, 2, 1'b1, 6, 1'b0, 1);
        board[3][2] = 4'd0;

        runMove("null_move", 3, 0, 3, 0, 0, 0, 1, 1'b1, 1, 1'b0, 0);
        runMove("empty_src", 4, 4, 4, 5, 0, 1, 1, 1'b1, 1, 1'b0, 0);
        board[3][1] = 4'd1;
        runMove("own_capture", 3, 0, 3, 1, 0, 1, 1, 1'b1, 1, 1'b0, 0);
        board[3][1] = 4'd9;
        runMove("enemy_capture", 3, 0, 3, 1, 0, 1, 1, 1'b1, 4, 1'b1, 1);
        board[3][1] = 4'd0;

        board[1][0] = 4'd2;
        runMove("knight_legal", 1, 0, 2, 2, 1, 2, 3, 1'b1, 5, 1'b1, 1);
        runMove("knight_illegal", 1, 0, 2, 2, 1, 2, 1, 1'b0, 3, 1'b0, 1);

        board[4][1] = 4'd1;
        runMove("pawn_double", 4, 1, 4, 3, 0, 2, 1, 1'b1, 5, 1'b1, 1);
        board[4][2] = 4'd9;
        runMove("pawn_double_blk", 4, 1, 4, 3, 0, 2, 1, 1'b1, 4, 1'b0, 1);
        board[4][2] = 4'd0;
        runMove("pawn_single", 4, 1, 4, 2, 0, 1, 1, 1'b1, 3, 1'b1, 1);

        board[2][0] = 4'd3;
        runMove("bishop_diag", 2, 0, 7, 5, 5, 5, 1, 1'b1, 8, 1'b1, 1);
        board[7][7] = 4'd12;
        runMove("rook_west", 7, 7, 0, 7, 7, 0, 1, 1'b1, 10, 1'b1, 1);
        board[5][5] = 4'd6;
        runMove("king_step", 5, 5, 6, 6, 1, 1, 2, 1'b1, 4, 1'b1, 1);
        board[5][5] = 4'd0;

        chk_latency = 1;
        chk_verdict = 1'b1;
        applyStimulus(3'd3, 3'd0, 3'd3, 3'd4);
        waitResp(cycles);
        checkOutput("stall_latency", cycles, 7);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_valid", resp_valid, 1);
            checkOutput("stall_legal", resp_legal, 1);
            checkOutput("stall_req_busy", req_ready, 0);
        end
        finishResp("stall");

        board[0][0] = 4'd5;
        applyStimulus(3'd0, 3'd0, 3'd7, 3'd7);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checkOutput("mid_scan_valid", resp_valid, 0);
        checkOutput("mid_scan_busy", req_ready, 0);
        reset = 1'b1;
        #1;
        checkOutput("abort_valid", resp_valid, 0);
        checkOutput("abort_ready", req_ready, 1);
        checkOutput("abort_piece", chk_piece, 0);
        old_x     = 3'd2;
        old_y     = 3'd2;
        new_x     = 3'd2;
        new_y     = 3'd2;
        req_valid = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        req_valid = 1'b0;
        checkOutput("held_req_accepted", req_ready, 0);
        tick();
        checkOutput("held_req_valid", resp_valid, 1);
        checkOutput("held_req_legal", resp_legal, 0);
        finishResp("held_req");

        // Recovery after abort: the diagonal queen move must complete normally.
        runMove("queen_long_diag", 0, 0, 7, 7, 7, 7, 1, 1'b1, 10, 1'b1, 1);

`ifdef MOVE_CHK_TIMEOUT_EN
        chk_enable  = 1'b0;
        start_count = 0;
        applyStimulus(3'd1, 3'd0, 3'd2, 3'd2);
        waitResp(cycles);
        checkOutput("timeout_latency", cycles, 19);
        checkOutput("timeout_legal", resp_legal, 0);
        checkOutput("timeout_err", resp_err, 1);
        checkOutput("timeout_starts", start_count, 1);
        finishResp("timeout");
        chk_enable = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
